instr_reader: RTL and testbench

INSTR_READER -- requirements
Module: instr_reader

---
 rtl/instr_register_pkg.sv | 35 +++
 rtl/instr_reader_alu.sv | 56 +++++
 rtl/instr_reader.sv | 144 ++++++++++++++
 tb/tb_instr_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the instruction register and everything that reads it.
//   address_t     : 5-bit register address (32 entries)
//   operand_t     : signed 32-bit operand
//   result_t      : signed 64-bit arithmetic result
//   opcode_t      : 4-bit opcode; encodings 8..15 are undefined
//   instruction_t : {opc, a, b} packed, opc in the most significant bits
// -----------------------------------------------------------------------------
package instr_register_pkg;

   localparam int unsigned NUM_REGS = 32;

   typedef logic [4:0]         address_t;
   typedef logic signed [31:0] operand_t;
   typedef logic signed [63:0] result_t;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t a;
      operand_t b;
   } instruction_t;

endpackage

// File: rtl/instr_reader_alu.sv
// -----------------------------------------------------------------------------
// instr_reader_alu
// Purely combinational arithmetic for one instruction. Operands are signed
// 32-bit, widened to 64 bits before every operation so MULT keeps the full
// product and no sum/difference can overflow.
// Ports:
//   opcode      in   opcode_t   operation select
//   a, b        in   operand_t  signed operands
//   result      out  result_t   signed 64-bit result (0 for undefined opcodes)
//   div_by_zero out  1          DIV/MOD attempted with b == 0
// Configuration macro: INSTR_READER_DIV_EN
//   defined   : DIV/MOD implemented (truncating), b == 0 gives 0 + div_by_zero
//   undefined : DIV/MOD return 0 with div_by_zero = 0, no divider is built
// -----------------------------------------------------------------------------
module instr_reader_alu
   import instr_register_pkg::*;
(
   input  opcode_t  opcode,
   input  operand_t a,
   input  operand_t b,
   output result_t  result,
   output logic     div_by_zero
);

   result_t a_ext;
   result_t b_ext;

   assign a_ext = {{32{a[31]}}, a};
   assign b_ext = {{32{b[31]}}, b};

   always_comb begin
      result      = '0;
      div_by_zero = 1'b0;
      case (opcode)
         ZERO:  result = '0;
         PASSA: result = a_ext;
         PASSB: result = b_ext;
         ADD:   result = a_ext + b_ext;
         SUB:   result = a_ext - b_ext;
         MULT:  result = a_ext * b_ext;
`ifdef INSTR_READER_DIV_EN
         // 64-bit division so INT_MIN / -1 yields +2^31 instead of wrapping.
         DIV: begin
            if (b == '0) div_by_zero = 1'b1;
            else         result      = a_ext / b_ext;
         end
         MOD: begin
            if (b == '0) div_by_zero = 1'b1;
            else         result      = a_ext % b_ext;
         end
`endif
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/instr_reader.sv
// -----------------------------------------------------------------------------
// instr_reader
// Walks a run of consecutive instruction-register entries, executes each one
// through instr_reader_alu and offers every result on a valid/ready port.
// Ports:
//   clk              in   1              rising-edge clock
//   reset            in   1              asynchronous, active-high
//   start            in   1              begin a run (sampled only in IDLE)
//   start_addr       in   address_t      first address of the run
//   num_instr        in   6              run length, 0..32
//   read_pointer     out  address_t      address presented to the register file
//   instruction_word in   instruction_t  combinational read data at read_pointer
//   result_valid     out  1              result offered
//   result_ready     in   1              consumer accepts result
//   result           out  result_t       signed 64-bit result
//   result_addr      out  address_t      address the result came from
//   result_opc       out  opcode_t       opcode of that instruction
//   div_by_zero      out  1              qualified by result_valid
//   busy             out  1              not IDLE
//   done             out  1              one-cycle pulse when a run finishes
// Configuration macro: INSTR_READER_DIV_EN (enables DIV/MOD in the ALU).
//
// Handshake: a result transfers on a rising clk edge where result_valid and
// result_ready are both high. While result_valid is high and ready is low,
// result, result_addr, result_opc, div_by_zero and read_pointer hold still.
// result_ready has no effect in any other state.
//
// FSM: IDLE -> FETCH -> EXEC -> OUTPUT -> (FETCH | DONE) -> IDLE.
// Every output is a register updated by the single FSM process.
// -----------------------------------------------------------------------------
module instr_reader
   import instr_register_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  address_t     start_addr,
   input  logic [5:0]   num_instr,
   output address_t     read_pointer,
   input  instruction_t instruction_word,
   output logic         result_valid,
   input  logic         result_ready,
   output result_t      result,
   output address_t     result_addr,
   output opcode_t      result_opc,
   output logic         div_by_zero,
   output logic         busy,
   output logic         done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_OUTPUT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t       state;
   logic [5:0]   remaining;
   instruction_t instr_q;

   result_t alu_result;
   logic    alu_dbz;

   instr_reader_alu u_alu (
      .opcode      (instr_q.opc),
      .a           (instr_q.a),
      .b           (instr_q.b),
      .result      (alu_result),
      .div_by_zero (alu_dbz)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         read_pointer <= '0;
         remaining    <= '0;
         instr_q      <= '0;
         result       <= '0;
         result_addr  <= '0;
         result_opc   <= ZERO;
         result_valid <= 1'b0;
         div_by_zero  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (num_instr != 6'd0) begin
                     read_pointer <= start_addr;
                     remaining    <= num_instr;
                     state        <= S_FETCH;
                  end else begin
                     // Empty run: no fetch, pointer untouched, straight to done.
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end

            S_FETCH: begin
               instr_q <= instruction_word;
               state   <= S_EXEC;
            end

            S_EXEC: begin
               result       <= alu_result;
               result_addr  <= read_pointer;
               result_opc   <= instr_q.opc;
               div_by_zero  <= alu_dbz;
               result_valid <= 1'b1;
               state        <= S_OUTPUT;
            end

            S_OUTPUT: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  // 5-bit add wraps 31 -> 0 on its own.
                  read_pointer <= read_pointer + 5'd1;
                  remaining    <= remaining - 6'd1;
                  if (remaining == 6'd1) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end

            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_reader.sv
// -----------------------------------------------------------------------------
// tb_instr_reader
// Directed sequence of runs over a randomly filled instruction memory.
// Expected results come from a longint reference model of the arithmetic
// rules and are queued per run; the DUT output is compared on the falling
// edge, away from the active rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_reader;
   import instr_register_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic         start;
   address_t     start_addr;
   logic [5:0]   num_instr;
   address_t     read_pointer;
   instruction_t instruction_word;
   logic         result_valid;
   logic         result_ready;
   result_t      result;
   address_t     result_addr;
   opcode_t      result_opc;
   logic         div_by_zero;
   logic         busy;
   logic         done;

   instruction_t mem [NUM_REGS];
   assign instruction_word = mem[read_pointer];

   instr_reader dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .start_addr       (start_addr),
      .num_instr        (num_instr),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .result_valid     (result_valid),
      .result_ready     (result_ready),
      .result           (result),
      .result_addr      (result_addr),
      .result_opc       (result_opc),
      .div_by_zero      (div_by_zero),
      .busy             (busy),
      .done             (done)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int done_seen = 0;
   logic [73:0] exp_q[$];   // {dbz, opc[3:0], addr[4:0], result[63:0]}
   address_t exp_ptr;

   always @(negedge clk) if (done === 1'b1) done_seen++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void ref_alu(input instruction_t ins, output logic [63:0] r, output logic dbz);
      longint sa;
      longint sb;
      int     op;
      sa  = $signed(ins.a);
      sb  = $signed(ins.b);
      op  = int'(ins.opc);
      r   = 64'd0;
      dbz = 1'b0;
      if (op == 1)      r = sa;
      else if (op == 2) r = sb;
      else if (op == 3) r = sa + sb;
      else if (op == 4) r = sa - sb;
      else if (op == 5) r = sa * sb;
`ifdef INSTR_READER_DIV_EN
      else if (op == 6 || op == 7) begin
         if (sb == 0) dbz = 1'b1;
         else         r = (op == 6) ? sa / sb : sa % sb;
      end
`endif
   endfunction

   function automatic instruction_t mk(input opcode_t o, input int a, input int b);
      instruction_t t;
      t.opc = o;
      t.a   = a;
      t.b   = b;
      return t;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < NUM_REGS; i++) begin
         mem[i].opc = opcode_t'(4'($urandom_range(0, 15)));
         mem[i].a   = ($urandom_range(0, 1) == 0) ? $urandom : int'($urandom_range(0, 200)) - 100;
         mem[i].b   = ($urandom_range(0, 3) == 0) ? 0 :
                      (($urandom_range(0, 1) == 0) ? $urandom : int'($urandom_range(1, 20)));
      end
   endtask

   task automatic build_expect(input address_t sa, input int n);
      logic [63:0] r;
      logic        d;
      address_t    a;
      for (int i = 0; i < n; i++) begin
         a = sa + 5'(i);
         ref_alu(mem[a], r, d);
         exp_q.push_back({d, mem[a].opc, a, r});
      end
   endtask

   // ---------------- drivers ----------------
   task automatic pulse_start(input address_t sa, input logic [5:0] n);
      @(negedge clk);
      start_addr = sa;
      num_instr  = n;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic run(input address_t sa, input int n, input bit hold_ready,
                      input int first_stall, input bit poke_start);
      logic [73:0] e;
      int          waited;
      int          stall;
      build_expect(sa, n);
      result_ready = hold_ready;
      pulse_start(sa, 6'(n));
      check("busy_after_start", busy, 1);
      for (int k = 0; k < n; k++) begin
         waited = 0;
         while (result_valid !== 1'b1 && waited < 20) begin
            if (poke_start && k == 1 && waited == 0) begin
               start      = 1'b1;
               start_addr = 5'd17;
               num_instr  = 6'd3;
            end
            @(negedge clk);
            start = 1'b0;
            waited++;
         end
         check("valid_seen", result_valid, 1);
         if (result_valid !== 1'b1) begin
            exp_q.delete();
            result_ready = 1'b0;
            return;
         end
         check("fetch_to_valid_latency", waited, 2);
         e = exp_q.pop_front();
         check("result", result, e[63:0]);
         check("result_addr", result_addr, e[68:64]);
         check("result_opc", result_opc, e[72:69]);
         check("div_by_zero", div_by_zero, e[73]);
         check("read_pointer", read_pointer, e[68:64]);
         if (hold_ready) begin
            @(negedge clk);
         end else begin
            stall = (k == 0) ? first_stall : $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
               @(negedge clk);
               check("stall_valid", result_valid, 1);
               check("stall_result", result, e[63:0]);
               check("stall_read_pointer", read_pointer, e[68:64]);
            end
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
         end
         check("valid_drop_after_handshake", result_valid, 0);
      end
      exp_ptr = sa + 5'(n);
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 1);
      @(negedge clk);
      result_ready = 1'b0;
      check("done_cleared", done, 0);
      check("busy_idle", busy, 0);
      check("read_pointer_after_run", read_pointer, exp_ptr);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      int dseen;
      int waited;
      reset        = 1'b1;
      start        = 1'b0;
      start_addr   = '0;
      num_instr    = '0;
      result_ready = 1'b0;
      fill_random();
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_read_pointer", read_pointer, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_result", result, 0);
      check("rst_result_opc", result_opc, ZERO);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      exp_ptr = '0;

      // Wrap run 30,31,0,1 with ready held high; known arithmetic cases
      mem[30] = mk(ADD, -5, 3);
      mem[31] = mk(MULT, 32'h7FFF_FFFF, 2);
      mem[0]  = mk(DIV, 7, 0);
      mem[1]  = mk(opcode_t'(4'd12), 9, 4);
      run(5'd30, 4, 1'b1, 0, 1'b0);

      // Backpressure: first result stalled 5 cycles; start poked while busy
      fill_random();
      mem[5] = mk(SUB, 100, -28);
      mem[6] = mk(MOD, -7, 0);
      run(5'd5, 6, 1'b0, 5, 1'b1);

      // Empty run: no fetch, done one cycle later
      pulse_start(5'd3, 6'd0);
      check("empty_done_pulse", done, 1);
      check("empty_busy", busy, 1);
      check("empty_no_fetch_ptr", read_pointer, exp_ptr);
      @(negedge clk);
      check("empty_done_cleared", done, 0);
      check("empty_busy_idle", busy, 0);

      // Full 32-entry random run from a random address
      fill_random();
      run(5'($urandom_range(0, 31)), 32, 1'b0, $urandom_range(0, 3), 1'b0);

      // Reset while a result is offered
      fill_random();
      pulse_start(5'd9, 6'd3);
      waited = 0;
      while (result_valid !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("pre_reset_valid", result_valid, 1);
      dseen = done_seen;
      #1 reset = 1'b1;
      #1;
      check("midrst_result_valid", result_valid, 0);
      check("midrst_result", result, 0);
      check("midrst_result_addr", result_addr, 0);
      check("midrst_result_opc", result_opc, ZERO);
      check("midrst_div_by_zero", div_by_zero, 0);
      check("midrst_read_pointer", read_pointer, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst_no_done_pulse", done_seen, dseen);
      check("midrst_stays_idle", busy, 0);
      exp_q.delete();

      // Recovery run after abort
      fill_random();
      run(5'd20, 3, 1'b0, 1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
